count_cmd_sched: RTL and testbench

- Front-end scheduler for the card-count datapath. Two command sources compete for it: the panel button decoder (requester 0) and the host/scan interface (requester 1).
- Arbitrates round-robin, checks each command against the counter's live status, and issues single-cycle strobes on the counter's add/back/deck inputs plus a shoe-clear strobe.
- Guarantees one command in flight, and that counter state has settled before the next command is checked.

---
 rtl/count_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/count_cmd_sched.sv | 111 +++++++++++
 tb/tb_count_cmd_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the card-count command scheduler: command codes,
// FSM state encoding and the strobe bundle registered toward the counter.
package count_pkg;

   localparam logic [2:0] CMD_NOP   = 3'd0;
   localparam logic [2:0] CMD_SMALL = 3'd1;
   localparam logic [2:0] CMD_SEVEN = 3'd2;
   localparam logic [2:0] CMD_LARGE = 3'd3;
   localparam logic [2:0] CMD_DECK  = 3'd4;
   localparam logic [2:0] CMD_BACK  = 3'd5;
   localparam logic [2:0] CMD_SHOE  = 3'd6;

   localparam int unsigned CARDS_PER_DECK_DEF = 52;
   localparam int unsigned MAX_DECK_DEF       = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   typedef struct packed {
      logic small_add;
      logic seven_add;
      logic large_add;
      logic deck_add;
      logic back;
      logic shoe_clr;
      logic rej;
   } strobe_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. The pointer names the requester that wins
// a tie and moves to the other side only when a grant is actually taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req_valid,
   output logic [1:0] grant,
   output logic       winner
);

   logic ptr_q, ptr_d;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant  = 2'b00;
      winner = 1'b0;
      ptr_d  = ptr_q;
      if (en) begin
         case (req_valid)
            2'b01: begin winner = 1'b0;  grant = 2'b01; end
            2'b10: begin winner = 1'b1;  grant = 2'b10; end
            2'b11: begin winner = ptr_q; grant = ptr_q ? 2'b10 : 2'b01; end
            default: ;
         endcase
         // A grant in IDLE is always taken, so the pointer can move right away.
         if (grant != 2'b00) ptr_d = ~winner;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/count_cmd_sched.sv
// Front-end scheduler for the card counter: round-robin accept, legality check
// against live counter status, one registered strobe per command, then settle.
module count_cmd_sched
   import count_pkg::*;
#(
   parameter int unsigned MAX_DECK       = MAX_DECK_DEF,
   parameter int unsigned CARDS_PER_DECK = CARDS_PER_DECK_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [2:0]  req_cmd0,
   input  logic [2:0]  req_cmd1,
   output logic [1:0]  req_ready,
   input  logic [15:0] cnt_total,
   input  logic [7:0]  cnt_deck,
   output logic        small_add,
   output logic        seven_add,
   output logic        large_add,
   output logic        deck_add,
   output logic        back,
   output logic        shoe_clr,
   output logic        rej,
   output logic [7:0]  rej_cnt,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [2:0]  cmd_q, cmd_d;
   strobe_t     out_q, out_d;
   logic [7:0]  rej_cnt_q, rej_cnt_d;
   logic [1:0]  grant;
   logic        winner;
   logic        arb_en;
   logic [15:0] card_limit;
   logic        below_limit;

   // Gating with rst_n keeps req_ready low while reset is held.
   assign arb_en = (state_q == ST_IDLE) && rst_n;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (arb_en),
      .req_valid (req_valid),
      .grant     (grant),
      .winner    (winner)
   );

   assign card_limit  = 16'(CARDS_PER_DECK) * {8'd0, cnt_deck};
   assign below_limit = cnt_total < card_limit;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      out_d     = '0;
      rej_cnt_d = rej_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               cmd_d   = winner ? req_cmd1 : req_cmd0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            case (cmd_q)
               CMD_SMALL: if (below_limit) out_d.small_add = 1'b1; else out_d.rej = 1'b1;
               CMD_SEVEN: if (below_limit) out_d.seven_add = 1'b1; else out_d.rej = 1'b1;
               CMD_LARGE: if (below_limit) out_d.large_add = 1'b1; else out_d.rej = 1'b1;
               CMD_DECK: begin
                  if (cnt_total == 16'd0 && cnt_deck < 8'(MAX_DECK)) out_d.deck_add = 1'b1;
                  else                                                out_d.rej      = 1'b1;
               end
               CMD_BACK:  if (cnt_total != 16'd0) out_d.back = 1'b1; else out_d.rej = 1'b1;
               CMD_SHOE:  out_d.shoe_clr = 1'b1;
               default: ;
            endcase
            state_d = ST_SETTLE;
         end
         ST_SETTLE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (out_d.rej && rej_cnt_q != 8'hFF) rej_cnt_d = rej_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= CMD_NOP;
         out_q     <= '0;
         rej_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         out_q     <= out_d;
         rej_cnt_q <= rej_cnt_d;
      end
   end

   assign req_ready = grant;
   assign small_add = out_q.small_add;
   assign seven_add = out_q.seven_add;
   assign large_add = out_q.large_add;
   assign deck_add  = out_q.deck_add;
   assign back      = out_q.back;
   assign shoe_clr  = out_q.shoe_clr;
   assign rej       = out_q.rej;
   assign rej_cnt   = rej_cnt_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_count_cmd_sched.sv
// Randomized scoreboard bench for count_cmd_sched: the driver predicts each
// accepted command's response, a monitor pops and compares on every output pulse.
module tb_count_cmd_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [2:0]  req_cmd0 = 3'd0;
   logic [2:0]  req_cmd1 = 3'd0;
   logic [1:0]  req_ready;
   logic [15:0] cnt_total = 16'd0;
   logic [7:0]  cnt_deck = 8'd0;
   logic        small_add, seven_add, large_add, deck_add, back, shoe_clr, rej;
   logic [7:0]  rej_cnt;
   logic        busy;

   count_cmd_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_cmd0  (req_cmd0),
      .req_cmd1  (req_cmd1),
      .req_ready (req_ready),
      .cnt_total (cnt_total),
      .cnt_deck  (cnt_deck),
      .small_add (small_add),
      .seven_add (seven_add),
      .large_add (large_add),
      .deck_add  (deck_add),
      .back      (back),
      .shoe_clr  (shoe_clr),
      .rej       (rej),
      .rej_cnt   (rej_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response bits: 0 small, 1 seven, 2 large, 3 deck, 4 back, 5 shoe, 6 rej.
   typedef struct {
      logic [6:0] vec;
      int         at;
      logic [7:0] rcnt;
   } exp_t;
   exp_t sb[$];

   bit m_ptr  = 1'b0;
   int m_rcnt = 0;

   function automatic logic [6:0] model_vec(input logic [2:0] cmd, input int tot, input int dk);
      int lim;
      lim = 52 * dk;
      case (cmd)
         3'd1:    return (tot < lim) ? 7'd1 : 7'd64;
         3'd2:    return (tot < lim) ? 7'd2 : 7'd64;
         3'd3:    return (tot < lim) ? 7'd4 : 7'd64;
         3'd4:    return (tot == 0 && dk < 255) ? 7'd8 : 7'd64;
         3'd5:    return (tot != 0) ? 7'd16 : 7'd64;
         3'd6:    return 7'd32;
         default: return 7'd0;
      endcase
   endfunction

   // Monitor: any pulse on a strobe or rej must match the oldest prediction.
   always @(negedge clk) begin
      logic [6:0] obs;
      exp_t e;
      if (rst_n) begin
         obs = {rej, shoe_clr, back, deck_add, large_add, seven_add, small_add};
         if (obs != 7'd0) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", {25'd0, obs}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("strobe_vec", {25'd0, obs}, {25'd0, e.vec});
               check("strobe_cycle", cyc, e.at);
               check("rej_cnt", {24'd0, rej_cnt}, {24'd0, e.rcnt});
            end
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 2'b00;
      m_ptr = 1'b0;
      m_rcnt = 0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [1:0] v, input logic [2:0] a0, input logic [2:0] a1,
                        input int tot, input int dk, input bit hold, input bit chk_busy,
                        input bit chg, output int acc);
      bit         got;
      bit         w;
      logic [2:0] c;
      logic [6:0] vec;
      exp_t       e;
      @(negedge clk);
      req_valid = v;
      req_cmd0  = a0;
      req_cmd1  = a1;
      cnt_total = 16'(tot);
      cnt_deck  = 8'(dk);
      got = 1'b0;
      acc = -1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_ready != 2'b00) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         if (chg && $urandom_range(0, 1) == 1) begin
            req_cmd0 = 3'($urandom_range(0, 7));
            req_cmd1 = 3'($urandom_range(0, 7));
         end
      end
      if (!got) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 2'b00;
         return;
      end
      acc = cyc;
      w = (v == 2'b10) ? 1'b1 : (v == 2'b01) ? 1'b0 : m_ptr;
      check("req_ready", {30'd0, req_ready}, w ? 32'd2 : 32'd1);
      if (chk_busy) check("busy_accept", {31'd0, busy}, 32'd0);
      m_ptr = ~w;
      c = w ? req_cmd1 : req_cmd0;
      vec = model_vec(c, tot, dk);
      if (vec == 7'd64 && m_rcnt < 255) m_rcnt++;
      if (vec != 7'd0) begin
         e.vec  = vec;
         e.at   = acc + 2;
         e.rcnt = 8'(m_rcnt);
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) req_valid = 2'b00;
      if (chk_busy) begin
         check("busy_issue", {31'd0, busy}, 32'd1);
         @(negedge clk);
         check("busy_settle", {31'd0, busy}, 32'd1);
         @(negedge clk);
         check("busy_idle", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("queue_drained", sb.size(), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int acc;
      int prev;
      int dk;
      int tot;
      int lim;

      apply_reset();
      #1;
      check("reset_ready", {30'd0, req_ready}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_rej_cnt", {24'd0, rej_cnt}, 32'd0);
      check("reset_strobes", {25'd0, rej, shoe_clr, back, deck_add, large_add, seven_add, small_add}, 32'd0);

      // DECK from an empty shoe, with busy tracked through the command.
      issue(2'b01, 3'd4, 3'd0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
      drain();

      // Both requesters holding LARGE: grants alternate, accepts 3 cycles apart.
      apply_reset();
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         issue(2'b11, 3'd3, 3'd3, 5, 1, 1'b1, 1'b0, 1'b0, acc);
         if (prev >= 0) check("accept_spacing", acc - prev, 32'd3);
         prev = acc;
      end
      req_valid = 2'b00;
      drain();

      // Card limit boundary and DECK / BACK / SHOE rules.
      issue(2'b01, 3'd1, 3'd0, 52, 1, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b01, 3'd1, 3'd0, 51, 1, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b10, 3'd0, 3'd4, 3, 1, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b10, 3'd0, 3'd4, 0, 255, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b10, 3'd0, 3'd4, 0, 254, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b01, 3'd5, 3'd0, 0, 3, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b01, 3'd5, 3'd0, 7, 3, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b10, 3'd0, 3'd6, 0, 0, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b01, 3'd7, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b11, 3'd2, 3'd2, 13259, 255, 1'b0, 1'b0, 1'b0, acc);
      drain();

      // Randomized mix with boundary-biased counter status and codes changing while waiting.
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 4))
            0:       dk = 0;
            1:       dk = 1;
            2:       dk = 254;
            3:       dk = 255;
            default: dk = int'($urandom_range(0, 255));
         endcase
         lim = 52 * dk;
         case ($urandom_range(0, 4))
            0:       tot = 0;
            1:       tot = (lim > 0) ? lim - 1 : 0;
            2:       tot = lim;
            3:       tot = lim + 1;
            default: tot = int'($urandom_range(0, 65535));
         endcase
         issue(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               tot, dk, 1'b0, 1'b0, 1'b1, acc);
      end
      drain();

      // Saturate the refusal counter.
      for (int n = 0; n < 260; n++)
         issue((n % 2 == 0) ? 2'b01 : 2'b10, 3'd5, 3'd5, 0, 0, 1'b0, 1'b0, 1'b0, acc);
      drain();
      check("rej_cnt_saturated", {24'd0, rej_cnt}, 32'd255);

      // Reset asserted during ISSUE drops the command.
      @(negedge clk);
      req_valid = 2'b01;
      req_cmd0  = 3'd1;
      cnt_total = 16'd0;
      cnt_deck  = 8'd1;
      #1;
      check("pre_reset_ready", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      m_ptr = 1'b0;
      m_rcnt = 0;
      #1;
      check("mid_reset_ready", {30'd0, req_ready}, 32'd0);
      check("mid_reset_busy", {31'd0, busy}, 32'd0);
      check("mid_reset_rej_cnt", {24'd0, rej_cnt}, 32'd0);
      check("mid_reset_strobes", {25'd0, rej, shoe_clr, back, deck_add, large_add, seven_add, small_add}, 32'd0);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      issue(2'b11, 3'd1, 3'd5, 10, 2, 1'b0, 1'b0, 1'b0, acc);
      issue(2'b11, 3'd1, 3'd5, 10, 2, 1'b0, 1'b0, 1'b0, acc);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
